// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge: command entry layout, AXI
// encodings and the read-issuer state enum.
package apb2axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_ID_W   = 4;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [AXI_ID_W-1:0]   id;
    logic                  is_write;
  } directory_entry_t;

  localparam int CMD_ENTRY_W = $bits(directory_entry_t);

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_ISSUE = 1'b1
  } rd_issuer_state_e;

  // Last byte of the burst is formed in 13 bits; bit 12 set means the burst leaves its 4KB page.
  function automatic logic crosses_4k(input logic [11:0] addr_lo,
                                      input logic [7:0]  len,
                                      input logic [2:0]  size,
                                      input logic [1:0]  burst);
    logic [12:0] beats;
    logic [12:0] last_byte;
    beats     = {5'b0, len} + 13'd1;
    last_byte = {1'b0, addr_lo} + (beats << size) - 13'd1;
    return last_byte[12] && (burst == AXI_BURST_INCR);
  endfunction

endpackage

// File: rtl/apb2axi_outstanding_ctr.sv
// Saturating in-flight transaction counter shared by the read and write issuers.
// A decrement at zero holds the count and raises underflow for that cycle.
module apb2axi_outstanding_ctr #(
  parameter int  MAX_OUTSTANDING = 8,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             at_max,
  output logic             underflow
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign at_max    = (count_reg >= CNT_W'(MAX_OUTSTANDING));
  assign underflow = dec && (count_reg == '0);
  assign count     = count_reg;

  always_comb begin
    count_next = count_reg;
    if (inc && !dec && !at_max) begin
      count_next = count_reg + CNT_W'(1);
    end else if (dec && !inc && (count_reg != '0)) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/apb2axi_rd_issuer.sv
// Pops read commands from the read request FIFO and presents them on AXI AR from registers,
// limiting reads in flight. Define APB2AXI_RD_4K_CHECK_EN to drop INCR bursts crossing 4KB.
module apb2axi_rd_issuer
  import apb2axi_pkg::*;
#(
  parameter int  MAX_OUTSTANDING = 8,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   rd_pop_vld,
  output logic                   rd_pop_rdy,
  input  logic [CMD_ENTRY_W-1:0] rd_pop_data,
  output logic [AXI_ID_W-1:0]    arid,
  output logic [AXI_ADDR_W-1:0]  araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic                   r_last_hs,
  output logic [CNT_W-1:0]       outstanding,
  output logic                   issuer_idle,
  output logic                   cnt_err,
  output logic                   bnd_err
);

  directory_entry_t entry;
  rd_issuer_state_e state_reg, state_next;

  logic                  arvalid_reg, arvalid_next;
  logic [AXI_ID_W-1:0]   arid_reg, arid_next;
  logic [AXI_ADDR_W-1:0] araddr_reg, araddr_next;
  logic [7:0]            arlen_reg, arlen_next;
  logic [2:0]            arsize_reg, arsize_next;
  logic [1:0]            arburst_reg, arburst_next;
  logic                  cnt_err_reg;

  logic pop;
  logic drop;
  logic ar_hs;
  logic at_max;
  logic underflow;
  logic unused_is_write;

  assign entry           = directory_entry_t'(rd_pop_data);
  assign unused_is_write = entry.is_write;

  // The held AR is only counted once accepted; ISSUE itself already blocks further pops.
  assign rd_pop_rdy = (state_reg == RD_IDLE) && rd_pop_vld && !at_max;
  assign pop        = rd_pop_vld && rd_pop_rdy;
  assign ar_hs      = arvalid_reg && arready;

  apb2axi_outstanding_ctr #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_outstanding_ctr (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .inc      (ar_hs),
    .dec      (r_last_hs),
    .count    (outstanding),
    .at_max   (at_max),
    .underflow(underflow)
  );

`ifdef APB2AXI_RD_4K_CHECK_EN
  logic bnd_err_reg;

  assign drop    = crosses_4k(entry.addr[11:0], entry.len, entry.size, entry.burst);
  assign bnd_err = bnd_err_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bnd_err_reg <= 1'b0;
    end else begin
      bnd_err_reg <= pop && drop;
    end
  end
`else
  assign drop    = 1'b0;
  assign bnd_err = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    arvalid_next = arvalid_reg;
    arid_next    = arid_reg;
    araddr_next  = araddr_reg;
    arlen_next   = arlen_reg;
    arsize_next  = arsize_reg;
    arburst_next = arburst_reg;
    case (state_reg)
      RD_IDLE: begin
        if (pop && !drop) begin
          araddr_next  = entry.addr;
          arlen_next   = entry.len;
          arsize_next  = entry.size;
          arburst_next = entry.burst;
          arid_next    = entry.id;
          arvalid_next = 1'b1;
          state_next   = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (ar_hs) begin
          arvalid_next = 1'b0;
          state_next   = RD_IDLE;
        end
      end
      default: begin
        arvalid_next = 1'b0;
        state_next   = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg   <= RD_IDLE;
      arvalid_reg <= 1'b0;
      arid_reg    <= '0;
      araddr_reg  <= '0;
      arlen_reg   <= '0;
      arsize_reg  <= '0;
      arburst_reg <= '0;
      cnt_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      arvalid_reg <= arvalid_next;
      arid_reg    <= arid_next;
      araddr_reg  <= araddr_next;
      arlen_reg   <= arlen_next;
      arsize_reg  <= arsize_next;
      arburst_reg <= arburst_next;
      if (underflow) begin
        cnt_err_reg <= 1'b1;
      end
    end
  end

  assign arvalid     = arvalid_reg;
  assign arid        = arid_reg;
  assign araddr      = araddr_reg;
  assign arlen       = arlen_reg;
  assign arsize      = arsize_reg;
  assign arburst     = arburst_reg;
  assign cnt_err     = cnt_err_reg;
  assign issuer_idle = (state_reg == RD_IDLE) && (outstanding == '0);

endmodule
